// File: rtl/palette_pkg.sv
// Shared widths, the write-buffer entry type and the video address helper for the palette lookup stage.
package palette_pkg;

    localparam int PAL_ADDR_W = 13;
    localparam int PAL_IDX_W  = 12;
    localparam int PAL_DATA_W = 16;

    typedef struct packed {
        logic [PAL_ADDR_W-1:0] addr;
        logic [PAL_DATA_W-1:0] data;
    } pal_wr_t;

    function automatic logic [PAL_ADDR_W-1:0] pal_video_addr(input logic bank,
                                                             input logic [PAL_IDX_W-1:0] idx);
        return {bank, idx};
    endfunction

endpackage

// File: rtl/palette_wrbuf.sv
// CPU palette write FIFO: entries of {addr, data}, power-of-2 depth, pointers wrap naturally.
module palette_wrbuf
    import palette_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  pal_wr_t push_data,
    input  logic    pop,
    output pal_wr_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);

    pal_wr_t          buf_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = buf_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            buf_mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/palette_lookup.sv
// Palette RAM stage: pixel index -> colour word PC, with buffered CPU writes drained on non-pixel cycles.
// Optional CPU read-back ports are enabled by defining PAL_CPU_READ_EN.
module palette_lookup
    import palette_pkg::*;
#(
    parameter int WRBUF_DEPTH = 4
) (
    input  logic                  CLK_24M,
    input  logic                  nRESET,
    input  logic                  PIXEL_CE,
    input  logic                  PAL_BANK,
    input  logic [PAL_IDX_W-1:0]  PIXEL_IDX,
    input  logic                  nBNK_IN,
    input  logic                  CPU_WR_VALID,
    output logic                  CPU_WR_READY,
    input  logic [PAL_ADDR_W-1:0] CPU_WR_ADDR,
    input  logic [PAL_DATA_W-1:0] CPU_WR_DATA,
    output logic [PAL_DATA_W-1:0] PC,
    output logic                  nBNKB
`ifdef PAL_CPU_READ_EN
    ,
    input  logic                  CPU_RD_REQ,
    input  logic [PAL_ADDR_W-1:0] CPU_RD_ADDR,
    output logic [PAL_DATA_W-1:0] CPU_RD_DATA,
    output logic                  CPU_RD_VALID
`endif
);

    localparam int PAL_WORDS = 1 << PAL_ADDR_W;

    logic [PAL_DATA_W-1:0] pal_ram [PAL_WORDS];
    logic [PAL_DATA_W-1:0] ram_dout;
    logic [PAL_ADDR_W-1:0] ram_addr;
    logic                  ram_we;

    logic                  rst_done_q;
    logic [1:0]            ph_q, ph_d;
    logic                  nbnk_s1_q, nbnk_s1_d;
    logic [PAL_DATA_W-1:0] pc_q, pc_d;
    logic                  nbnkb_q, nbnkb_d;

    pal_wr_t               wr_head;
    pal_wr_t               wr_entry;
    logic                  wr_full;
    logic                  wr_empty;
    logic                  wr_push;
    logic                  drain;

    assign CPU_WR_READY = rst_done_q & ~wr_full;
    assign wr_push      = CPU_WR_VALID & CPU_WR_READY;
    assign wr_entry     = '{addr: CPU_WR_ADDR, data: CPU_WR_DATA};
    assign drain        = ~PIXEL_CE & ~wr_empty;
    assign ram_we       = drain;
    assign PC           = pc_q;
    assign nBNKB        = nbnkb_q;

    palette_wrbuf #(
        .DEPTH(WRBUF_DEPTH)
    ) u_wrbuf (
        .clk       (CLK_24M),
        .rst_n     (nRESET),
        .push      (wr_push),
        .push_data (wr_entry),
        .pop       (drain),
        .head      (wr_head),
        .full      (wr_full),
        .empty     (wr_empty)
    );

`ifdef PAL_CPU_READ_EN
    logic                  rd_pend_q, rd_pend_d;
    logic [PAL_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_stage_q, rd_stage_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [PAL_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                  rd_issue;

    // Only issued once the buffer is empty, so it never collides with a drain.
    assign rd_issue     = rd_pend_q & wr_empty & ~PIXEL_CE;
    assign CPU_RD_DATA  = rd_data_q;
    assign CPU_RD_VALID = rd_valid_q;

    always_comb begin
        rd_pend_d  = rd_pend_q;
        rd_addr_d  = rd_addr_q;
        if (rd_issue) begin
            rd_pend_d = 1'b0;
        end else if (CPU_RD_REQ && !rd_pend_q) begin
            rd_pend_d = 1'b1;
            rd_addr_d = CPU_RD_ADDR;
        end
        rd_stage_d = rd_issue;
        rd_valid_d = rd_stage_q;
        rd_data_d  = rd_stage_q ? ram_dout : rd_data_q;
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_stage_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_addr_q  <= rd_addr_d;
            rd_stage_q <= rd_stage_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign ram_addr = PIXEL_CE ? pal_video_addr(PAL_BANK, PIXEL_IDX)
                    : (drain ? wr_head.addr : rd_addr_q);
`else
    assign ram_addr = PIXEL_CE ? pal_video_addr(PAL_BANK, PIXEL_IDX) : wr_head.addr;
`endif

    always_ff @(posedge CLK_24M) begin
        if (ram_we) begin
            pal_ram[ram_addr] <= wr_head.data;
        end
        ram_dout <= pal_ram[ram_addr];
    end

    // ph_q == 0 marks the cycle where ram_dout holds the video read.
    always_comb begin
        ph_d      = PIXEL_CE ? 2'd0 : ((ph_q == 2'd3) ? 2'd3 : ph_q + 2'd1);
        nbnk_s1_d = PIXEL_CE ? nBNK_IN : nbnk_s1_q;
        pc_d      = pc_q;
        nbnkb_d   = nbnkb_q;
        if (ph_q == 2'd0) begin
            pc_d    = ram_dout;
            nbnkb_d = nbnk_s1_q;
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            rst_done_q <= 1'b0;
            ph_q       <= 2'd3;
            nbnk_s1_q  <= 1'b0;
            pc_q       <= '0;
            nbnkb_q    <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            ph_q       <= ph_d;
            nbnk_s1_q  <= nbnk_s1_d;
            pc_q       <= pc_d;
            nbnkb_q    <= nbnkb_d;
        end
    end

endmodule

// File: tb/tb_palette_lookup.sv
// Directed bench for palette_lookup: video latency, banks, write-buffer fill/drain, deferred writes, reset.
module tb_palette_lookup;

    logic        CLK_24M = 1'b0;
    logic        nRESET;
    logic        PIXEL_CE;
    logic        PAL_BANK;
    logic [11:0] PIXEL_IDX;
    logic        nBNK_IN;
    logic        CPU_WR_VALID;
    logic        CPU_WR_READY;
    logic [12:0] CPU_WR_ADDR;
    logic [15:0] CPU_WR_DATA;
    logic [15:0] PC;
    logic        nBNKB;
`ifdef PAL_CPU_READ_EN
    logic        CPU_RD_REQ;
    logic [12:0] CPU_RD_ADDR;
    logic [15:0] CPU_RD_DATA;
    logic        CPU_RD_VALID;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] cur_pc;
    logic        cur_nb;
    logic [12:0] t_addr [5];
    logic [15:0] t_data [5];

    always #5 CLK_24M = ~CLK_24M;

    palette_lookup #(.WRBUF_DEPTH(4)) dut (
        .CLK_24M      (CLK_24M),
        .nRESET       (nRESET),
        .PIXEL_CE     (PIXEL_CE),
        .PAL_BANK     (PAL_BANK),
        .PIXEL_IDX    (PIXEL_IDX),
        .nBNK_IN      (nBNK_IN),
        .CPU_WR_VALID (CPU_WR_VALID),
        .CPU_WR_READY (CPU_WR_READY),
        .CPU_WR_ADDR  (CPU_WR_ADDR),
        .CPU_WR_DATA  (CPU_WR_DATA),
        .PC           (PC),
        .nBNKB        (nBNKB)
`ifdef PAL_CPU_READ_EN
        ,
        .CPU_RD_REQ   (CPU_RD_REQ),
        .CPU_RD_ADDR  (CPU_RD_ADDR),
        .CPU_RD_DATA  (CPU_RD_DATA),
        .CPU_RD_VALID (CPU_RD_VALID)
`endif
    );

    task automatic tick();
        @(posedge CLK_24M);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("cmp %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cpu_write(input logic [12:0] addr, input logic [15:0] data);
        CPU_WR_VALID = 1'b1;
        CPU_WR_ADDR  = addr;
        CPU_WR_DATA  = data;
        tick();
        CPU_WR_VALID = 1'b0;
        tick();
    endtask

    // PC must hold for one clock after the strobe, then update.
    task automatic pixel(input string tag, input logic bank, input logic [11:0] idx,
                         input logic nb, input logic [15:0] exp_pc);
        PIXEL_CE  = 1'b1;
        PAL_BANK  = bank;
        PIXEL_IDX = idx;
        nBNK_IN   = nb;
        tick();
        PIXEL_CE  = 1'b0;
        check({tag, "_hold_pc"}, PC, cur_pc);
        tick();
        check({tag, "_pc"}, PC, exp_pc);
        check({tag, "_nbnkb"}, {15'd0, nBNKB}, {15'd0, nb});
        cur_pc = exp_pc;
        cur_nb = nb;
    endtask

    initial begin
        nRESET = 1'b0;
        PIXEL_CE = 1'b0; PAL_BANK = 1'b0; PIXEL_IDX = '0; nBNK_IN = 1'b0;
        CPU_WR_VALID = 1'b0; CPU_WR_ADDR = '0; CPU_WR_DATA = '0;
`ifdef PAL_CPU_READ_EN
        CPU_RD_REQ = 1'b0; CPU_RD_ADDR = '0;
`endif
        cur_pc = 16'h0000; cur_nb = 1'b0;

        // Reset state and READY release timing
        tick(); tick();
        check("rst_ready", {15'd0, CPU_WR_READY}, 16'd0);
        check("rst_pc", PC, 16'h0000);
        check("rst_nbnkb", {15'd0, nBNKB}, 16'd0);
        nRESET = 1'b1;
        check("rel_ready_before_clk", {15'd0, CPU_WR_READY}, 16'd0);
        tick();
        check("rel_ready_after_clk", {15'd0, CPU_WR_READY}, 16'd1);

        // 1: basic write then video read
        cpu_write(13'h0005, 16'h1234);
        pixel("t1", 1'b0, 12'h005, 1'b1, 16'h1234);

        // 2: bank 1 entry, bank 0 untouched
        cpu_write(13'h1005, 16'hABCD);
        pixel("t2_b1", 1'b1, 12'h005, 1'b1, 16'hABCD);
        pixel("t2_b0", 1'b0, 12'h005, 1'b0, 16'h1234);

        // 3: fill buffer while strobing (no drain), then drain in order
        t_addr[0] = 13'h0020; t_data[0] = 16'h1111;
        t_addr[1] = 13'h0021; t_data[1] = 16'h2222;
        t_addr[2] = 13'h0020; t_data[2] = 16'h3333;
        t_addr[3] = 13'h0022; t_data[3] = 16'h4444;
        t_addr[4] = 13'h0020; t_data[4] = 16'h5555;
        PIXEL_CE = 1'b1; PAL_BANK = 1'b0; PIXEL_IDX = 12'h005; nBNK_IN = 1'b0;
        CPU_WR_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            CPU_WR_ADDR = t_addr[i];
            CPU_WR_DATA = t_data[i];
            check($sformatf("t3_ready_%0d", i), {15'd0, CPU_WR_READY}, 16'd1);
            tick();
        end
        check("t3_full", {15'd0, CPU_WR_READY}, 16'd0);
        CPU_WR_ADDR = t_addr[4];
        CPU_WR_DATA = t_data[4];
        tick();
        check("t3_full_hold", {15'd0, CPU_WR_READY}, 16'd0);
        PIXEL_CE = 1'b0;
        tick();
        check("t3_reopen", {15'd0, CPU_WR_READY}, 16'd1);
        tick();
        CPU_WR_VALID = 1'b0;
        repeat (6) tick();
        cur_pc = 16'h1234; cur_nb = 1'b0;
        check("t3_pc_idle", PC, 16'h1234);
        pixel("t3_last", 1'b0, 12'h020, 1'b1, 16'h5555);
        pixel("t3_a21", 1'b0, 12'h021, 1'b1, 16'h2222);
        pixel("t3_a22", 1'b0, 12'h022, 1'b0, 16'h4444);

        // 4: push landing on a strobe cycle; video sees the old word
        CPU_WR_VALID = 1'b1; CPU_WR_ADDR = 13'h0005; CPU_WR_DATA = 16'h5A5A;
        PIXEL_CE = 1'b1; PAL_BANK = 1'b0; PIXEL_IDX = 12'h005; nBNK_IN = 1'b1;
        tick();
        CPU_WR_VALID = 1'b0; PIXEL_CE = 1'b0;
        check("t4_hold", PC, cur_pc);
        tick();
        check("t4_old", PC, 16'h1234);
        cur_pc = 16'h1234; cur_nb = 1'b1;
        pixel("t4_new", 1'b0, 12'h005, 1'b1, 16'h5A5A);

        // 5: reset with 3 entries buffered
        cpu_write(13'h0030, 16'h0303);
        PIXEL_CE = 1'b1; PAL_BANK = 1'b0; PIXEL_IDX = 12'h005; nBNK_IN = 1'b1;
        CPU_WR_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            CPU_WR_ADDR = 13'h0030 + 13'(i);
            CPU_WR_DATA = 16'hDEA0 + 16'(i);
            tick();
        end
        CPU_WR_VALID = 1'b0;
        nRESET = 1'b0;
        #1;
        check("t5_rst_ready", {15'd0, CPU_WR_READY}, 16'd0);
        check("t5_rst_pc", PC, 16'h0000);
        check("t5_rst_nbnkb", {15'd0, nBNKB}, 16'd0);
        tick(); tick();
        PIXEL_CE = 1'b0;
        nRESET = 1'b1;
        tick();
        check("t5_rel_ready", {15'd0, CPU_WR_READY}, 16'd1);
        // An empty buffer takes exactly 4 pushes before READY drops.
        PIXEL_CE = 1'b1;
        CPU_WR_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            CPU_WR_ADDR = 13'h0040 + 13'(i);
            CPU_WR_DATA = 16'h0400 + 16'(i);
            check($sformatf("t5_empty_ready_%0d", i), {15'd0, CPU_WR_READY}, 16'd1);
            tick();
        end
        check("t5_refull", {15'd0, CPU_WR_READY}, 16'd0);
        CPU_WR_VALID = 1'b0;
        PIXEL_CE = 1'b0;
        repeat (6) tick();
        cur_pc = 16'h5A5A; cur_nb = 1'b1;
        pixel("t5_lost", 1'b0, 12'h030, 1'b1, 16'h0303);
        pixel("t5_keep_b1", 1'b1, 12'h005, 1'b0, 16'hABCD);
        pixel("t5_post", 1'b0, 12'h043, 1'b1, 16'h0403);

`ifdef PAL_CPU_READ_EN
        // 6: read-after-write coherence through the buffer
        begin
            logic got;
            cpu_write(13'h0FFF, 16'h0111);
            CPU_WR_VALID = 1'b1; CPU_WR_ADDR = 13'h0FFF; CPU_WR_DATA = 16'h7FFF;
            tick();
            CPU_WR_VALID = 1'b0;
            CPU_RD_REQ = 1'b1; CPU_RD_ADDR = 13'h0FFF;
            tick();
            CPU_RD_REQ = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (CPU_RD_VALID) begin
                    got = 1'b1;
                    break;
                end
                tick();
            end
            check("t6_valid_seen", {15'd0, got}, 16'd1);
            check("t6_data", CPU_RD_DATA, 16'h7FFF);
            tick();
            check("t6_pulse", {15'd0, CPU_RD_VALID}, 16'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
